sparse_mac_row_acc: RTL and testbench

//  Parametrised successor to the sparse MAC row. Each beat carries NLANE non-zero (act, weight, col_index)

---
 rtl/sparse_mac_row_acc.sv | 169 ++++++++++++++++
 tb/tb_sparse_mac_row_acc.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_mac_row_acc.sv
// Sparse MAC row: NLANE products per beat scatter-accumulated into NCOL psums.
// Load/compute/drain handshakes, 1-stage multiply, optional saturation.
module sparse_mac_row_acc #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 20,
    parameter int NCOL    = 8,
    parameter int NLANE   = 4,
    parameter int IDX_BW  = 3,
    parameter int SAT     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [NCOL*PSUM_BW-1:0]   load_psum_flat,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NLANE*BW-1:0]       in_act_flat,
    input  logic [NLANE*BW-1:0]       in_weight_flat,
    input  logic [NLANE*IDX_BW-1:0]   in_widx_flat,
    input  logic [NLANE-1:0]          in_lane_en,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCOL*PSUM_BW-1:0]   out_psum_flat,
    output logic [NCOL-1:0]           out_overflow,
    output logic                      busy
);

    localparam int PW     = 2 * BW;
    localparam int SUM_BW = PSUM_BW + $clog2(NLANE) + 1;

    localparam logic signed [SUM_BW-1:0] PMAX =
        {{(SUM_BW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [SUM_BW-1:0] PMIN = ~PMAX;
    localparam logic [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_p_vld;
    logic signed [PW-1:0]       r_prod [NLANE];
    logic [IDX_BW-1:0]          r_idx  [NLANE];
    logic signed [PSUM_BW-1:0]  r_psum [NCOL];
    logic [NCOL-1:0]            r_ovf;

    logic signed [PW-1:0]       w_prod [NLANE];
    logic signed [SUM_BW-1:0]   w_sum  [NCOL];
    logic [PSUM_BW-1:0]         w_nxt  [NCOL];
    logic [NCOL-1:0]            w_hi;
    logic [NCOL-1:0]            w_lo;
    logic                       w_load_hs;
    logic                       w_beat_hs;

    assign w_load_hs = load_valid & load_ready;
    assign w_beat_hs = in_valid & in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (load_valid) w_state_nxt = S_ACC;
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-lane signed products, zero for disabled lanes
    always_comb begin
        for (int l = 0; l < NLANE; l++) begin
            w_prod[l] = '0;
            if (in_lane_en[l])
                w_prod[l] = PW'($signed(in_act_flat[l*BW +: BW]))
                          * PW'($signed(in_weight_flat[l*BW +: BW]));
        end
    end

    // Stage-1 valid
    always_ff @(posedge clk) begin
        if (reset) r_p_vld <= 1'b0;
        else       r_p_vld <= w_beat_hs;
    end

    // Stage-1 product and index capture
    always_ff @(posedge clk) begin
        if (w_beat_hs) begin
            for (int l = 0; l < NLANE; l++) begin
                r_prod[l] <= w_prod[l];
                r_idx[l]  <= in_widx_flat[l*IDX_BW +: IDX_BW];
            end
        end
    end

    // Wide column sums, range check and saturate/wrap
    always_comb begin
        for (int c = 0; c < NCOL; c++) begin
            w_sum[c] = SUM_BW'(r_psum[c]);
            if (r_p_vld) begin
                for (int l = 0; l < NLANE; l++) begin
                    if (int'(r_idx[l]) == c)
                        w_sum[c] = w_sum[c] + SUM_BW'(r_prod[l]);
                end
            end
            w_hi[c]  = w_sum[c] > PMAX;
            w_lo[c]  = w_sum[c] < PMIN;
            w_nxt[c] = w_sum[c][PSUM_BW-1:0];
            if (SAT != 0 && w_hi[c]) w_nxt[c] = SAT_MAX;
            if (SAT != 0 && w_lo[c]) w_nxt[c] = SAT_MIN;
        end
    end

    // Psum registers: load in IDLE, accumulate when stage 1 holds a beat
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCOL; c++) r_psum[c] <= '0;
        end else if (w_load_hs) begin
            for (int c = 0; c < NCOL; c++)
                r_psum[c] <= load_psum_flat[c*PSUM_BW +: PSUM_BW];
        end else if (r_p_vld) begin
            for (int c = 0; c < NCOL; c++) r_psum[c] <= w_nxt[c];
        end
    end

    // Sticky overflow flags, cleared by load
    always_ff @(posedge clk) begin
        if (reset)          r_ovf <= '0;
        else if (w_load_hs) r_ovf <= '0;
        else if (r_p_vld)   r_ovf <= r_ovf | w_hi | w_lo;
    end

    // Psum registers drive the output bus in every state
    always_comb begin
        out_psum_flat = '0;
        for (int c = 0; c < NCOL; c++)
            out_psum_flat[c*PSUM_BW +: PSUM_BW] = r_psum[c];
    end

    assign out_overflow = r_ovf;

endmodule

// File: tb/tb_sparse_mac_row_acc.sv
// Bench for sparse_mac_row_acc: three instances (20b sat, 8b sat, 8b wrap)
// share stimulus and are compared every cycle to a behavioural model.
module tb_sparse_mac_row_acc;

    localparam int BW = 4;
    localparam int NC = 8;
    localparam int NL = 4;
    localparam int IB = 3;
    localparam int WA = 20;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic reset;
    logic load_valid, in_valid, in_last, out_ready;
    logic [NC*WA-1:0] ld_a_flat;
    logic [NC*WB-1:0] ld_b_flat;
    logic [NL*BW-1:0] act_f, wt_f;
    logic [NL*IB-1:0] idx_f;
    logic [NL-1:0]    en_f;

    logic [2:0] lr, ir, ov, bz;
    logic [NC-1:0] ovf_a, ovf_b, ovf_c;
    logic [NC*WA-1:0] ps_a;
    logic [NC*WB-1:0] ps_b, ps_c;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sparse_mac_row_acc #(.PSUM_BW(WA), .SAT(1)) u_a (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(lr[0]), .load_psum_flat(ld_a_flat),
        .in_valid(in_valid), .in_ready(ir[0]), .in_act_flat(act_f),
        .in_weight_flat(wt_f), .in_widx_flat(idx_f), .in_lane_en(en_f),
        .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
        .out_psum_flat(ps_a), .out_overflow(ovf_a), .busy(bz[0]));

    sparse_mac_row_acc #(.PSUM_BW(WB), .SAT(1)) u_b (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(lr[1]), .load_psum_flat(ld_b_flat),
        .in_valid(in_valid), .in_ready(ir[1]), .in_act_flat(act_f),
        .in_weight_flat(wt_f), .in_widx_flat(idx_f), .in_lane_en(en_f),
        .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
        .out_psum_flat(ps_b), .out_overflow(ovf_b), .busy(bz[1]));

    sparse_mac_row_acc #(.PSUM_BW(WB), .SAT(0)) u_c (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(lr[2]), .load_psum_flat(ld_b_flat),
        .in_valid(in_valid), .in_ready(ir[2]), .in_act_flat(act_f),
        .in_weight_flat(wt_f), .in_widx_flat(idx_f), .in_lane_en(en_f),
        .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
        .out_psum_flat(ps_c), .out_overflow(ovf_c), .busy(bz[2]));

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 accepting beats, 2 flush, 3 draining
    int m_ph;
    bit m_ok = 1'b0;
    bit m_pv;
    int m_pend [NC];
    int m_ps [3][NC];
    bit m_ov [3][NC];

    function automatic int wid(int d);
        return (d == 0) ? WA : WB;
    endfunction

    function automatic int wrapw(int v, int w);
        int span, lo, r;
        span = 1 << w;
        lo   = -(1 << (w - 1));
        r    = (v - lo) % span;
        if (r < 0) r += span;
        return r + lo;
    endfunction

    always @(posedge clk) begin
        int s, mx, mn, nph, a, b, ix;
        bit hs;
        if (reset) begin
            m_ok = 1'b1;
            m_ph = 0;
            m_pv = 1'b0;
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < NC; c++) begin
                    m_ps[d][c] = 0;
                    m_ov[d][c] = 1'b0;
                end
        end else if (m_ok) begin
            hs  = (m_ph == 1) && in_valid;
            nph = m_ph;
            if (m_pv) begin
                for (int d = 0; d < 3; d++) begin
                    mx = (1 << (wid(d) - 1)) - 1;
                    mn = -(1 << (wid(d) - 1));
                    for (int c = 0; c < NC; c++) begin
                        s = m_ps[d][c] + m_pend[c];
                        if (s > mx || s < mn) m_ov[d][c] = 1'b1;
                        if (d == 2)      s = wrapw(s, wid(d));
                        else if (s > mx) s = mx;
                        else if (s < mn) s = mn;
                        m_ps[d][c] = s;
                    end
                end
            end
            if (m_ph == 0 && load_valid) begin
                for (int c = 0; c < NC; c++) begin
                    m_ps[0][c] = $signed(ld_a_flat[c*WA +: WA]);
                    m_ps[1][c] = $signed(ld_b_flat[c*WB +: WB]);
                    m_ps[2][c] = $signed(ld_b_flat[c*WB +: WB]);
                    for (int d = 0; d < 3; d++) m_ov[d][c] = 1'b0;
                end
            end
            case (m_ph)
                0: if (load_valid) nph = 1;
                1: if (in_valid && in_last) nph = 2;
                2: nph = 3;
                default: if (out_ready) nph = 0;
            endcase
            m_pv = hs;
            if (hs) begin
                for (int c = 0; c < NC; c++) m_pend[c] = 0;
                for (int l = 0; l < NL; l++) begin
                    a  = $signed(act_f[l*BW +: BW]);
                    b  = $signed(wt_f[l*BW +: BW]);
                    ix = int'(idx_f[l*IB +: IB]);
                    if (en_f[l] && ix < NC) m_pend[ix] += a * b;
                end
            end
            m_ph = nph;
        end
    end

    task automatic chkv(string nm, logic [NC*WA-1:0] act, logic [NC*WA-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(string nm, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        logic [NC*WA-1:0] ea;
        logic [NC*WB-1:0] eb, ec;
        logic [NC-1:0] oa, ob, oc;
        logic [3:0] ectl;
        if (m_ok) begin
            ea = '0;
            eb = '0;
            ec = '0;
            for (int c = 0; c < NC; c++) begin
                ea[c*WA +: WA] = WA'(m_ps[0][c]);
                eb[c*WB +: WB] = WB'(m_ps[1][c]);
                ec[c*WB +: WB] = WB'(m_ps[2][c]);
                oa[c] = m_ov[0][c];
                ob[c] = m_ov[1][c];
                oc[c] = m_ov[2][c];
            end
            ectl = {m_ph == 0, m_ph == 1, m_ph == 3, m_ph != 0};
            for (int d = 0; d < 3; d++)
                chkv($sformatf("ctrl%0d", d),
                     {lr[d], ir[d], ov[d], bz[d]}, ectl);
            chkv("psum_a", ps_a, ea);
            chkv("psum_b", ps_b, eb);
            chkv("psum_c", ps_c, ec);
            chkv("ovf_a", ovf_a, oa);
            chkv("ovf_b", ovf_b, ob);
            chkv("ovf_c", ovf_c, oc);
        end
    end

    // ---------------- stimulus ----------------
    function automatic int psa(int c);
        return $signed(ps_a[c*WA +: WA]);
    endfunction
    function automatic int psb(int c);
        return $signed(ps_b[c*WB +: WB]);
    endfunction
    function automatic int psc(int c);
        return $signed(ps_c[c*WB +: WB]);
    endfunction

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_lanes();
        act_f = '0;
        wt_f  = '0;
        idx_f = '0;
        en_f  = '0;
    endtask

    task automatic set_lane(int l, int a, int w, int ix);
        act_f[l*BW +: BW] = BW'(a);
        wt_f[l*BW +: BW]  = BW'(w);
        idx_f[l*IB +: IB] = IB'(ix);
        en_f[l]           = 1'b1;
    endtask

    task automatic rand_lanes();
        act_f = NL*BW'($urandom);
        wt_f  = NL*BW'($urandom);
        idx_f = NL*IB'($urandom);
        en_f  = NL'($urandom);
    endtask

    task automatic set_ld(int c, int va, int vb);
        ld_a_flat[c*WA +: WA] = WA'(va);
        ld_b_flat[c*WB +: WB] = WB'(vb);
    endtask

    task automatic do_load();
        int n = 0;
        load_valid = 1'b1;
        while (!lr[0] && n < 20) begin
            wait_edge();
            n++;
        end
        if (n == 20) chki("load_timeout", 0, 1);
        wait_edge();
        load_valid = 1'b0;
    endtask

    task automatic beat(bit last);
        int n = 0;
        in_valid = 1'b1;
        in_last  = last;
        while (!ir[0] && n < 20) begin
            wait_edge();
            n++;
        end
        if (n == 20) chki("beat_timeout", 0, 1);
        wait_edge();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(int hold);
        int n = 0;
        out_ready = 1'b0;
        repeat (hold) wait_edge();
        while (!ov[0] && n < 20) begin
            wait_edge();
            n++;
        end
        if (n == 20) chki("drain_timeout", 0, 1);
        out_ready = 1'b1;
        wait_edge();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, v;
        bit abort;
        reset      = 1'b1;
        load_valid = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        ld_a_flat  = '0;
        ld_b_flat  = '0;
        clr_lanes();
        repeat (2) wait_edge();
        reset = 1'b0;
        chki("rst_load_ready", lr[0], 1);
        chki("rst_busy", bz[0], 0);
        chki("rst_in_ready", ir[0], 0);

        // defaults: mixed lanes into columns 0, 1, 7
        for (int c = 0; c < NC; c++) set_ld(c, 0, 0);
        do_load();
        set_lane(0, 3, 2, 0);
        set_lane(1, -4, 5, 1);
        set_lane(2, 7, 7, 7);
        set_lane(3, 1, -1, 0);
        beat(1'b1);
        chki("t1_ov_flush", ov[0], 0);
        wait_edge();
        chki("t1_ov_drain", ov[0], 1);
        chki("t1_p0", psa(0), 5);
        chki("t1_p1", psa(1), -20);
        chki("t1_p7", psa(7), 49);
        chki("t1_p3", psa(3), 0);
        chki("t1_ovf", int'(ovf_a), 0);
        drain(0);

        // duplicate index, two lanes disabled
        for (int c = 0; c < NC; c++) set_ld(c, 0, 0);
        set_ld(2, 100, 100);
        do_load();
        clr_lanes();
        for (int l = 0; l < NL; l++) set_lane(l, 2, 3, 2);
        en_f = 4'b0101;
        beat(1'b1);
        wait_edge();
        chki("t2_p2", psa(2), 112);
        drain(0);

        // saturation vs wrap on 8-bit instances
        for (int c = 0; c < NC; c++) set_ld(c, 0, 0);
        set_ld(0, 120, 120);
        do_load();
        clr_lanes();
        set_lane(0, 7, 7, 0);
        beat(1'b1);
        wait_edge();
        chki("t3_sat_p0", psb(0), 127);
        chki("t3_sat_ovf", int'(ovf_b[0]), 1);
        chki("t3_wrap_p0", psc(0), -87);
        chki("t3_wrap_ovf", int'(ovf_c[0]), 1);
        chki("t3_wide_p0", psa(0), 169);
        chki("t3_wide_ovf", int'(ovf_a[0]), 0);
        drain(0);

        // back-to-back beats, consumer stalls 5 cycles
        for (int c = 0; c < NC; c++) set_ld(c, 0, 0);
        do_load();
        clr_lanes();
        set_lane(0, 1, 1, 3);
        beat(1'b0);
        beat(1'b0);
        beat(1'b1);
        wait_edge();
        for (int i = 0; i < 5; i++) begin
            chki("t4_ov_hold", ov[0], 1);
            chki("t4_ir_hold", ir[0], 0);
            chki("t4_p3_hold", psa(3), 3);
            wait_edge();
        end
        out_ready = 1'b1;
        wait_edge();
        out_ready = 1'b0;
        chki("t4_idle", lr[0], 1);
        chki("t4_p3_kept", psa(3), 3);

        // reset with a product sitting in stage 1
        set_ld(0, 50, 50);
        do_load();
        clr_lanes();
        set_lane(0, 2, 2, 0);
        beat(1'b0);
        reset = 1'b1;
        wait_edge();
        reset = 1'b0;
        chki("t5_p0", psa(0), 0);
        chki("t5_busy", bz[0], 0);
        wait_edge();
        chki("t5_p0_after", psa(0), 0);

        // ignored inputs: in_valid in IDLE, load_valid in ACC and DRAIN
        set_lane(0, 3, 3, 0);
        in_valid = 1'b1;
        repeat (2) wait_edge();
        in_valid = 1'b0;
        chki("t6_idle_p0", psa(0), 0);
        chki("t6_idle_busy", bz[0], 0);
        set_ld(0, 10, 10);
        do_load();
        set_ld(0, 77, 77);
        load_valid = 1'b1;
        repeat (2) wait_edge();
        chki("t6_acc_p0", psa(0), 10);
        chki("t6_acc_ir", ir[0], 1);
        load_valid = 1'b0;
        clr_lanes();
        set_lane(0, 1, 1, 0);
        beat(1'b1);
        wait_edge();
        load_valid = 1'b1;
        repeat (2) wait_edge();
        load_valid = 1'b0;
        chki("t6_drain_ov", ov[0], 1);
        chki("t6_drain_p0", psa(0), 11);
        drain(0);

        // randomized tiles
        for (int t = 0; t < 40; t++) begin
            abort = 1'b0;
            rand_lanes();
            in_valid = 1'(($urandom % 3) == 0);
            repeat ($urandom % 3) wait_edge();
            in_valid = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if ($urandom % 3 == 0)
                    v = ($urandom % 2) ? 524287 - int'($urandom % 60)
                                       : -524288 + int'($urandom % 60);
                else
                    v = int'($urandom % 4001) - 2000;
                set_ld(c, v, int'($urandom % 256) - 128);
            end
            do_load();
            nb = 1 + int'($urandom % 6);
            for (int b = 0; b < nb && !abort; b++) begin
                if ($urandom % 3 == 0) begin
                    rand_lanes();
                    load_valid = 1'($urandom);
                    repeat (1 + $urandom % 2) wait_edge();
                    load_valid = 1'b0;
                end
                rand_lanes();
                beat(b == nb - 1);
                if (t % 9 == 4 && b == 0 && nb > 1) begin
                    reset = 1'b1;
                    wait_edge();
                    reset = 1'b0;
                    abort = 1'b1;
                end
            end
            if (!abort) drain(int'($urandom % 4));
        end

        repeat (3) wait_edge();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
